run_control_unit: RTL and testbench

RUN_CONTROL_UNIT -- requirements
Module: run_control_unit

---
 rtl/run_control_unit_pkg.sv | 20 ++
 rtl/run_control_unit_sat_counter.sv | 30 +++
 rtl/run_control_unit.sv | 175 +++++++++++++++++
 tb/tb_run_control_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/run_control_unit_pkg.sv
// run_control_unit_pkg
// Shared processor package for the run-control slice.
//   DATAPATH_WIDTH : width of the core PC and instruction words
//   HALT_ENCODING  : default instruction word that requests a halt
//   run_state_t    : run-control FSM states
package run_control_unit_pkg;

    localparam int DATAPATH_WIDTH = 16;

    localparam logic [DATAPATH_WIDTH-1:0] HALT_ENCODING = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        RESET_HOLD,
        RUN,
        DONE,
        TIMEOUT
    } run_state_t;

endpackage

// File: rtl/run_control_unit_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, count returns to 0
//   clear  : synchronous clear, wins over enable
//   enable : increment by one, holding at all-ones instead of wrapping
//   count  : current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Clear has priority so a restart always begins from zero even if the
    // counter would also be enabled that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_control_unit.sv
// run_control_unit
// Sequences a processor core through reset, run and termination, and
// reports how the run ended.
//   clk, rst_n   : clock and asynchronous active-low reset
//   start        : one-cycle pulse, honoured only in IDLE, DONE, TIMEOUT
//   pc           : core program counter, sampled every RUN cycle
//   instr_valid  : instr carries a retiring instruction this cycle
//   instr        : retiring instruction word
//   core_rst_n   : active-low reset driven to the core
//   running      : high while in RUN
//   done         : sticky, a HALT or self-loop ended the run
//   timeout      : sticky, the cycle budget ran out
//   cycle_count  : RUN cycles elapsed (saturating)
//   instr_count  : instructions retired (saturating)
//   final_pc     : pc captured on the terminating cycle
module run_control_unit
    import run_control_unit_pkg::*;
#(
    parameter int                XLEN         = DATAPATH_WIDTH,
    parameter int                RESET_CYCLES = 2,
    parameter int                MAX_CYCLES   = 20,
    parameter int                STALL_LIMIT  = 4,
    parameter logic [XLEN-1:0]   HALT_INSTR   = XLEN'(HALT_ENCODING),
    parameter int                CW           = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] pc,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr,
    output logic            core_rst_n,
    output logic            running,
    output logic            done,
    output logic            timeout,
    output logic [CW-1:0]   cycle_count,
    output logic [CW-1:0]   instr_count,
    output logic [XLEN-1:0] final_pc
);

    run_state_t      state, state_nx;
    logic [7:0]      hold_cnt, hold_cnt_nx;
    logic [3:0]      stall_cnt, stall_cnt_nx;
    logic [XLEN-1:0] prev_pc, prev_pc_nx;
    logic            prev_valid, prev_valid_nx;
    logic            core_rst_n_nx, running_nx, done_nx, timeout_nx;
    logic [XLEN-1:0] final_pc_nx;
    logic            start_accept;
    logic            halt_hit, stall_hit, budget_hit;
    logic            in_run;

    assign in_run = (state == RUN);

    sat_counter #(.WIDTH(CW)) u_cycle_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_accept),
        .enable (in_run),
        .count  (cycle_count)
    );

    sat_counter #(.WIDTH(CW)) u_instr_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_accept),
        .enable (in_run && instr_valid),
        .count  (instr_count)
    );

    // State and every output are plain flops so nothing on the input side
    // can reach an output without passing through a clock edge. Reset pulls
    // core_rst_n low immediately, aborting any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            stall_cnt  <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            core_rst_n <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            final_pc   <= '0;
        end else begin
            state      <= state_nx;
            hold_cnt   <= hold_cnt_nx;
            stall_cnt  <= stall_cnt_nx;
            prev_pc    <= prev_pc_nx;
            prev_valid <= prev_valid_nx;
            core_rst_n <= core_rst_n_nx;
            running    <= running_nx;
            done       <= done_nx;
            timeout    <= timeout_nx;
            final_pc   <= final_pc_nx;
        end
    end

    // Next-state logic. The first RUN cycle has no earlier pc to compare
    // with, so prev_valid gates the self-loop detector. The budget check
    // looks one count ahead because cycle_count increments on the same edge
    // that leaves RUN; a halt on that cycle still takes priority.
    always_comb begin
        state_nx      = state;
        hold_cnt_nx   = hold_cnt;
        stall_cnt_nx  = stall_cnt;
        prev_pc_nx    = prev_pc;
        prev_valid_nx = prev_valid;
        core_rst_n_nx = core_rst_n;
        running_nx    = running;
        done_nx       = done;
        timeout_nx    = timeout;
        final_pc_nx   = final_pc;
        start_accept  = 1'b0;
        halt_hit      = 1'b0;
        stall_hit     = 1'b0;
        budget_hit    = 1'b0;

        case (state)
            IDLE, DONE, TIMEOUT: begin
                if (start) begin
                    state_nx      = RESET_HOLD;
                    start_accept  = 1'b1;
                    hold_cnt_nx   = '0;
                    stall_cnt_nx  = '0;
                    prev_valid_nx = 1'b0;
                    core_rst_n_nx = 1'b0;
                    running_nx    = 1'b0;
                    done_nx       = 1'b0;
                    timeout_nx    = 1'b0;
                    final_pc_nx   = '0;
                end
            end

            RESET_HOLD: begin
                if (hold_cnt == 8'(RESET_CYCLES - 1)) begin
                    state_nx      = RUN;
                    core_rst_n_nx = 1'b1;
                    running_nx    = 1'b1;
                end else begin
                    hold_cnt_nx = hold_cnt + 8'd1;
                end
            end

            RUN: begin
                prev_pc_nx    = pc;
                prev_valid_nx = 1'b1;
                if (prev_valid && (pc == prev_pc)) begin
                    stall_cnt_nx = stall_cnt + 4'd1;
                    stall_hit    = (stall_cnt == 4'(STALL_LIMIT - 1));
                end else begin
                    stall_cnt_nx = '0;
                end
                halt_hit   = instr_valid && (instr == HALT_INSTR);
                budget_hit = (cycle_count == CW'(MAX_CYCLES - 1));
                if (halt_hit || stall_hit) begin
                    state_nx    = DONE;
                    running_nx  = 1'b0;
                    done_nx     = 1'b1;
                    final_pc_nx = pc;
                end else if (budget_hit) begin
                    state_nx    = TIMEOUT;
                    running_nx  = 1'b0;
                    timeout_nx  = 1'b1;
                    final_pc_nx = pc;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_run_control_unit.sv
// tb_run_control_unit
// Self-checking bench for run_control_unit. Each run is described as a table
// of per-cycle pc/instr_valid/instr values; a reference model walks the table
// to find when and how the run must end, and the bench then drives the DUT
// and compares its outputs against that prediction.
module tb_run_control_unit;

    localparam int          XLEN  = 16;
    localparam int          RC    = 2;
    localparam int          MAXC  = 20;
    localparam int          SL    = 4;
    localparam int          CW    = 16;
    localparam logic [15:0] HALT  = 16'h0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic            instr_valid = 1'b0;
    logic [XLEN-1:0] instr = '0;
    logic            core_rst_n, running, done, timeout;
    logic [CW-1:0]   cycle_count, instr_count;
    logic [XLEN-1:0] final_pc;

    int tests = 0;
    int fails = 0;

    logic [15:0] spc[MAXC];
    logic        sv[MAXC];
    logic [15:0] si[MAXC];

    run_control_unit #(
        .XLEN(XLEN), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
        .STALL_LIMIT(SL), .HALT_INSTR(HALT), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
        .instr_valid(instr_valid), .instr(instr),
        .core_rst_n(core_rst_n), .running(running), .done(done),
        .timeout(timeout), .cycle_count(cycle_count),
        .instr_count(instr_count), .final_pc(final_pc)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: walk the per-cycle table, counting retired
    // instructions and the length of the current run of repeated pc values,
    // and stop at the first HALT, self-loop or exhausted budget.
    task automatic modelRun(output int term, output logic edone, output logic eto,
                            output int eic, output logic [15:0] epc);
        int repeats = 0;
        term = MAXC; edone = 1'b0; eto = 1'b0; eic = 0; epc = '0;
        for (int k = 0; k < MAXC; k++) begin
            if (sv[k]) eic++;
            if (k > 0 && spc[k] == spc[k-1]) repeats++;
            else repeats = 0;
            if ((sv[k] && si[k] == HALT) || repeats >= SL) begin
                term = k + 1; edone = 1'b1; epc = spc[k];
                return;
            end
            if (k + 1 == MAXC) begin
                term = MAXC; eto = 1'b1; epc = spc[k];
                return;
            end
        end
    endtask

    function automatic logic [15:0] nonHalt();
        return 16'($urandom_range(1, 16'hFFFF));
    endfunction

    // Fill the stimulus table for one run.
    // 0: five 0x0013 then HALT   1: self-loop at 0x0010 from cycle 3
    // 2: incrementing pc, no halt 3: HALT on the last budget cycle
    // 4: small pc alphabet with occasional HALT   5: HALT at a random cycle
    task automatic buildScenario(input int mode);
        logic [15:0] base = 16'($urandom);
        int          idx  = $urandom_range(0, MAXC - 1);
        for (int k = 0; k < MAXC; k++) begin
            case (mode)
                0: begin spc[k] = 16'h0200 + 16'(2*k); sv[k] = 1'b1; si[k] = (k == 5) ? HALT : 16'h0013; end
                1: begin spc[k] = (k < 2) ? 16'h0100 + 16'(2*k) : 16'h0010; sv[k] = 1'($urandom_range(0,1)); si[k] = nonHalt(); end
                4: begin
                    spc[k] = 16'($urandom_range(0, 3));
                    sv[k]  = 1'($urandom_range(0, 1));
                    si[k]  = ($urandom_range(0, 7) == 0) ? HALT : nonHalt();
                end
                default: begin spc[k] = base + 16'(k); sv[k] = 1'($urandom_range(0,1)); si[k] = nonHalt(); end
            endcase
        end
        if (mode == 3) begin sv[MAXC-1] = 1'b1; si[MAXC-1] = HALT; end
        if (mode == 5) begin sv[idx] = 1'b1; si[idx] = HALT; end
    endtask

    // Pulse start and follow the core reset hold into RUN.
    task automatic startSequence(input string tag);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        checkOutput({tag, ".hold1_core_rst_n"}, 32'(core_rst_n), 32'd0);
        checkOutput({tag, ".hold1_done"}, 32'(done), 32'd0);
        checkOutput({tag, ".hold1_timeout"}, 32'(timeout), 32'd0);
        checkOutput({tag, ".hold1_cycles"}, 32'(cycle_count), 32'd0);
        checkOutput({tag, ".hold1_instrs"}, 32'(instr_count), 32'd0);
        checkOutput({tag, ".hold1_final_pc"}, 32'(final_pc), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, ".hold2_core_rst_n"}, 32'(core_rst_n), 32'd0);
        checkOutput({tag, ".hold2_running"}, 32'(running), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".run_core_rst_n"}, 32'(core_rst_n), 32'd1);
        checkOutput({tag, ".run_running"}, 32'(running), 32'd1);
    endtask

    // Drive one complete run from the table and check the termination.
    task automatic applyStimulus(input int mode, input string tag);
        int          term, eic;
        logic        edone, eto;
        logic [15:0] epc;
        buildScenario(mode);
        modelRun(term, edone, eto, eic, epc);
        startSequence(tag);
        for (int k = 0; k < term; k++) begin
            pc = spc[k]; instr_valid = sv[k]; instr = si[k];
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (k + 1 < term) begin
                checkOutput({tag, ".running"}, 32'(running), 32'd1);
                checkOutput({tag, ".cycles"}, 32'(cycle_count), 32'(k + 1));
            end
        end
        start = 1'b0;
        checkOutput({tag, ".done"}, 32'(done), 32'(edone));
        checkOutput({tag, ".timeout"}, 32'(timeout), 32'(eto));
        checkOutput({tag, ".running_end"}, 32'(running), 32'd0);
        checkOutput({tag, ".cycle_count"}, 32'(cycle_count), 32'(term));
        checkOutput({tag, ".instr_count"}, 32'(instr_count), 32'(eic));
        checkOutput({tag, ".final_pc"}, 32'(final_pc), 32'(epc));
        checkOutput({tag, ".exclusive"}, 32'(done & timeout), 32'd0);
        for (int k = 0; k < 3; k++) begin
            pc = 16'($urandom); instr_valid = 1'b1; instr = 16'($urandom_range(0, 1));
            @(negedge clk);
        end
        checkOutput({tag, ".frozen_cycles"}, 32'(cycle_count), 32'(term));
        checkOutput({tag, ".frozen_instrs"}, 32'(instr_count), 32'(eic));
        checkOutput({tag, ".frozen_final_pc"}, 32'(final_pc), 32'(epc));
        checkOutput({tag, ".frozen_core_rst_n"}, 32'(core_rst_n), 32'd1);
        checkOutput({tag, ".frozen_done"}, 32'(done), 32'(edone));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".core_rst_n"}, 32'(core_rst_n), 32'd0);
        checkOutput({tag, ".running"}, 32'(running), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".timeout"}, 32'(timeout), 32'd0);
        checkOutput({tag, ".cycle_count"}, 32'(cycle_count), 32'd0);
        checkOutput({tag, ".instr_count"}, 32'(instr_count), 32'd0);
        checkOutput({tag, ".final_pc"}, 32'(final_pc), 32'd0);
    endtask

    initial begin
        #12;
        checkResetValues("por");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("idle");

        applyStimulus(0, "halt");
        applyStimulus(1, "selfloop");
        applyStimulus(2, "budget");
        applyStimulus(3, "collision");

        // Abort in the seventh RUN cycle, between clock edges.
        buildScenario(2);
        startSequence("abort");
        for (int k = 0; k < 6; k++) begin
            pc = spc[k]; instr_valid = sv[k]; instr = si[k];
            @(negedge clk);
        end
        checkOutput("abort.cycles_before", 32'(cycle_count), 32'd6);
        pc = spc[6]; instr_valid = sv[6]; instr = si[6];
        #2 rst_n = 1'b0;
        #1;
        checkResetValues("abort");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("after_abort");

        applyStimulus(2, "restart");
        for (int r = 0; r < 8; r++) begin
            applyStimulus((r % 2 == 0) ? 4 : 5, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
